// File: rtl/adxl355_pkg.sv
// Shared definitions for the ADXL355 burst reader: register map, command encoding,
// sample geometry and the reader state encoding.
package adxl355_pkg;

  localparam logic [7:0] ADXL355_XDATA3 = 8'h08;
  localparam logic [7:0] ADXL355_YDATA3 = 8'h0B;
  localparam logic [7:0] ADXL355_ZDATA3 = 8'h0E;

  localparam int unsigned ADXL355_N_DATA   = 9;
  localparam int unsigned ADXL355_SAMPLE_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_GAP
  } state_e;

  // Read command: register address in bits 7:1, R/W bit (1 = read) in bit 0.
  function automatic logic [7:0] read_cmd(input logic [6:0] addr);
    return {addr, 1'b1};
  endfunction

endpackage

// File: rtl/adxl355_sclk_tick.sv
// Half-period timer for the SPI clock: pulses every half_period cycles while
// enabled, and starts counting from zero each time it is enabled.
module adxl355_sclk_tick
  import adxl355_pkg::*;
#(
  parameter int unsigned half_period = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CW = (half_period > 1) ? $clog2(half_period) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          last;

  always_comb begin
    last  = (cnt_q == CW'(half_period - 1));
    cnt_d = cnt_q;
    if (!i_en || last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    o_tick = i_en && last;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adxl355_rd.sv
// ADXL355 data reader: on each accepted DRDY pulse, performs one SPI mode-0 burst
// read of the X/Y/Z data registers and presents the unpacked 20-bit samples.
module adxl355_rd
  import adxl355_pkg::*;
#(
  parameter int unsigned clk_hz     = 40000000,
  parameter int unsigned spi_hz     = 5000000,
  parameter logic [7:0]  start_addr = ADXL355_XDATA3,
  parameter int unsigned n_data     = ADXL355_N_DATA
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic                        i_drdy,
  output logic                        o_csn,
  output logic                        o_sclk,
  output logic                        o_mosi,
  input  logic                        i_miso,
  output logic [ADXL355_SAMPLE_W-1:0] o_x,
  output logic [ADXL355_SAMPLE_W-1:0] o_y,
  output logic [ADXL355_SAMPLE_W-1:0] o_z,
  output logic                        o_valid,
  output logic                        o_busy,
  output logic [7:0]                  o_missed
);

  localparam int unsigned H     = clk_hz / (2 * spi_hz);
  localparam int unsigned NBITS = 8 * (1 + n_data);
  localparam int unsigned RXW   = 8 * n_data;
  localparam int unsigned BCW   = $clog2(NBITS);
  localparam int unsigned SW    = ADXL355_SAMPLE_W;
  localparam logic [7:0]  CMD   = read_cmd(start_addr[6:0]);

  if (H < 1) begin : g_bad_half_period
    $error("adxl355_rd: clk_hz/(2*spi_hz) must be at least 1");
  end
  if (n_data < ADXL355_N_DATA) begin : g_bad_n_data
    $error("adxl355_rd: n_data must cover the X/Y/Z data registers");
  end

  state_e           state_q, state_d;
  logic             csn_q, csn_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [SW-1:0]    x_q, x_d;
  logic [SW-1:0]    y_q, y_d;
  logic [SW-1:0]    z_q, z_d;
  logic [7:0]       missed_q, missed_d;
  logic [6:0]       tx_q, tx_d;
  logic [RXW-1:0]   rx_q, rx_d;
  logic [BCW-1:0]   bit_q, bit_d;
  logic             tick;

  // The timer runs continuously from SETUP through GAP, so phase boundaries
  // stay aligned and the final tick also ends the CSN-high gap.
  adxl355_sclk_tick #(
    .half_period(H)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (state_q != ST_IDLE),
    .o_tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    csn_d    = csn_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    missed_d = missed_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    bit_d    = bit_q;

    if (i_drdy && i_enable && (state_q != ST_IDLE) && (missed_q != 8'hFF)) begin
      missed_d = missed_q + 8'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_drdy && i_enable) begin
          state_d = ST_SETUP;
          csn_d   = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = CMD[7];
          tx_d    = CMD[6:0];
          rx_d    = '0;
          bit_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            rx_d   = {rx_q[RXW-2:0], i_miso};
            mosi_d = tx_q[6];
            tx_d   = {tx_q[5:0], 1'b0};
          end else if (bit_q == BCW'(NBITS - 1)) begin
            state_d = ST_DONE;
            csn_d   = 1'b1;
          end else begin
            bit_d  = bit_q + BCW'(1);
            sclk_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Command-byte bits have already shifted out of the top of rx.
        valid_d = 1'b1;
        x_d     = rx_q[RXW-1 -: SW];
        y_d     = rx_q[RXW-25 -: SW];
        z_d     = rx_q[RXW-49 -: SW];
        state_d = tick ? ST_IDLE : ST_GAP;
        busy_d  = !tick;
      end
      ST_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        csn_d   = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      csn_q    <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      missed_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      csn_q    <= csn_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      missed_q <= missed_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      bit_q    <= bit_d;
    end
  end

  assign o_csn    = csn_q;
  assign o_sclk   = sclk_q;
  assign o_mosi   = mosi_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;
  assign o_x      = x_q;
  assign o_y      = y_q;
  assign o_z      = z_q;
  assign o_missed = missed_q;

endmodule

// File: tb/tb_adxl355_rd.sv
// Directed bench for adxl355_rd: a default-rate instance (H=4) and a fast
// instance (H=1), each attached to a behavioural ADXL355 SPI responder.
module tb_adxl355_rd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int t0 = 0;

  // Device stream: one byte clocked out during the command, then the data bytes.
  logic [79:0] stream = {8'hA5, 72'h12345F80000AFFFFF3};

  // Default-rate instance
  logic        rst_n = 1'b1, en = 1'b1, drdy = 1'b0;
  logic        csn, sclk, mosi, miso, valid, busy;
  logic [19:0] x, y, z;
  logic [7:0]  missed;

  // Fast instance
  logic        f_rst_n = 1'b1, f_en = 1'b1, f_drdy = 1'b0;
  logic        f_csn, f_sclk, f_mosi, f_miso, f_valid, f_busy;
  logic [19:0] f_x, f_y, f_z;
  logic [7:0]  f_missed;

  adxl355_rd #(
    .clk_hz(40000000), .spi_hz(5000000), .start_addr(8'h08), .n_data(9)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_drdy(drdy),
    .o_csn(csn), .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso),
    .o_x(x), .o_y(y), .o_z(z), .o_valid(valid), .o_busy(busy), .o_missed(missed)
  );

  adxl355_rd #(
    .clk_hz(40000000), .spi_hz(20000000), .start_addr(8'h08), .n_data(9)
  ) dut_fast (
    .i_clk(clk), .i_rst_n(f_rst_n), .i_enable(f_en), .i_drdy(f_drdy),
    .o_csn(f_csn), .o_sclk(f_sclk), .o_mosi(f_mosi), .i_miso(f_miso),
    .o_x(f_x), .o_y(f_y), .o_z(f_z), .o_valid(f_valid), .o_busy(f_busy), .o_missed(f_missed)
  );

  // Responder + monitor, default instance
  int          idx0 = 0, rises0 = 0, rises0_done = 0, vcnt0 = 0, vcyc0 = 0, fall0 = 0, rise0 = 0;
  logic [79:0] mcap0 = '0, mcap0_done = '0;
  logic        pcsn0 = 1'b1, psclk0 = 1'b0;
  assign miso = (idx0 < 80) ? stream[7'(79 - idx0)] : 1'b0;

  always @(negedge clk) begin
    if (csn) begin
      if (!pcsn0) begin
        rise0       <= cyc;
        mcap0_done  <= mcap0;
        rises0_done <= rises0;
      end
      idx0 <= 0;
    end else begin
      if (pcsn0) begin
        fall0  <= cyc;
        rises0 <= 0;
        mcap0  <= '0;
      end else if (!psclk0 && sclk) begin
        rises0 <= rises0 + 1;
        mcap0  <= {mcap0[78:0], mosi};
      end
      if (psclk0 && !sclk) idx0 <= idx0 + 1;
    end
    if (valid) begin
      vcnt0 <= vcnt0 + 1;
      vcyc0 <= cyc;
    end
    pcsn0  <= csn;
    psclk0 <= sclk;
  end

  // Responder + monitor, fast instance
  int          idx1 = 0, rises1 = 0, rises1_done = 0, vcnt1 = 0, vcyc1 = 0;
  logic [79:0] mcap1 = '0, mcap1_done = '0;
  logic        pcsn1 = 1'b1, psclk1 = 1'b0;
  assign f_miso = (idx1 < 80) ? stream[7'(79 - idx1)] : 1'b0;

  always @(negedge clk) begin
    if (f_csn) begin
      if (!pcsn1) begin
        mcap1_done  <= mcap1;
        rises1_done <= rises1;
      end
      idx1 <= 0;
    end else begin
      if (pcsn1) begin
        rises1 <= 0;
        mcap1  <= '0;
      end else if (!psclk1 && f_sclk) begin
        rises1 <= rises1 + 1;
        mcap1  <= {mcap1[78:0], f_mosi};
      end
      if (psclk1 && !f_sclk) idx1 <= idx1 + 1;
    end
    if (f_valid) begin
      vcnt1 <= vcnt1 + 1;
      vcyc1 <= cyc;
    end
    pcsn1  <= f_csn;
    psclk1 <= f_sclk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to cycle n of the current transaction (cycle 0 = DRDY cycle).
  task automatic goto(input int n);
    while (cyc - t0 < n) step();
  endtask

  task automatic start_txn();
    step();
    drdy = 1'b1;
    t0 = cyc;
    step();
    drdy = 1'b0;
  endtask

  task automatic pulse_at(input int n);
    goto(n);
    drdy = 1'b1;
    step();
    drdy = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    f_rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    f_rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    step();
    rst_n = 1'b0;
    f_rst_n = 1'b0;
    #1;
    checks++; if (csn !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b want 1", csn); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", mosi); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({x, y, z} !== 60'h0) begin errors++; $display("FAIL reset_xyz: got %h want 0", {x, y, z}); end
    checks++; if (missed !== 8'h00) begin errors++; $display("FAIL reset_missed: got %h want 00", missed); end
    checks++; if (f_csn !== 1'b1) begin errors++; $display("FAIL reset_fast_csn: got %b want 1", f_csn); end
    repeat (2) step();
    rst_n = 1'b1;
    f_rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    int v0;
    v0 = vcnt0;
    start_txn();
    checks++; if ({csn, busy} !== 2'b01) begin errors++; $display("FAIL start_csn_busy: got %b want 01", {csn, busy}); end
    goto(644);
    checks++; if (csn !== 1'b0) begin errors++; $display("FAIL csn_low_644: got %b want 0", csn); end
    goto(645);
    checks++; if (csn !== 1'b1) begin errors++; $display("FAIL csn_high_645: got %b want 1", csn); end
    goto(648);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_648: got %b want 1", busy); end
    goto(649);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_649: got %b want 0", busy); end
    goto(660);
    checks++; if (vcnt0 - v0 != 1) begin errors++; $display("FAIL valid_count: got %0d want 1", vcnt0 - v0); end
    checks++; if (vcyc0 - t0 != 646) begin errors++; $display("FAIL valid_cycle: got %0d want 646", vcyc0 - t0); end
    checks++; if (fall0 - t0 != 1) begin errors++; $display("FAIL csn_fall_cycle: got %0d want 1", fall0 - t0); end
    checks++; if (rise0 - t0 != 645) begin errors++; $display("FAIL csn_rise_cycle: got %0d want 645", rise0 - t0); end
    checks++; if (x !== 20'h12345) begin errors++; $display("FAIL x: got %h want 12345", x); end
    checks++; if (y !== 20'h80000) begin errors++; $display("FAIL y: got %h want 80000", y); end
    checks++; if (z !== 20'hFFFFF) begin errors++; $display("FAIL z: got %h want fffff", z); end
    checks++; if (rises0_done != 80) begin errors++; $display("FAIL sclk_rises: got %0d want 80", rises0_done); end
    checks++; if (mcap0_done[79:72] !== 8'h11) begin errors++; $display("FAIL mosi_cmd: got %h want 11", mcap0_done[79:72]); end
    checks++; if (mcap0_done[71:0] !== 72'h0) begin errors++; $display("FAIL mosi_tail: got %h want 0", mcap0_done[71:0]); end
    checks++; if (missed !== 8'h00) begin errors++; $display("FAIL single_missed: got %h want 00", missed); end
  endtask

  task automatic test_missed();
    int v0;
    apply_reset();
    v0 = vcnt0;
    start_txn();
    pulse_at(100);
    pulse_at(300);
    goto(640);
    checks++; if (missed !== 8'd2) begin errors++; $display("FAIL missed_two: got %0d want 2", missed); end
    goto(649);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", busy); end
    drdy = 1'b1;
    step();
    drdy = 1'b0;
    checks++; if ({csn, busy} !== 2'b01) begin errors++; $display("FAIL b2b_start: got %b want 01", {csn, busy}); end
    goto(1300);
    checks++; if (vcnt0 - v0 != 2) begin errors++; $display("FAIL b2b_valid_count: got %0d want 2", vcnt0 - v0); end
    checks++; if (vcyc0 - t0 != 1295) begin errors++; $display("FAIL b2b_valid_cycle: got %0d want 1295", vcyc0 - t0); end
    checks++; if (missed !== 8'd2) begin errors++; $display("FAIL b2b_missed: got %0d want 2", missed); end
  endtask

  task automatic test_saturate();
    int v0;
    apply_reset();
    v0 = vcnt0;
    start_txn();
    for (int i = 0; i < 300; i++) pulse_at(2 + 2 * i);
    goto(644);
    checks++; if (missed !== 8'd255) begin errors++; $display("FAIL sat_missed: got %0d want 255", missed); end
    goto(660);
    checks++; if (missed !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d want 255", missed); end
    checks++; if (vcnt0 - v0 != 1) begin errors++; $display("FAIL sat_valid_count: got %0d want 1", vcnt0 - v0); end
  endtask

  task automatic test_enable();
    int v0, f0;
    apply_reset();
    en = 1'b0;
    f0 = fall0;
    step();
    drdy = 1'b1;
    step();
    drdy = 1'b0;
    repeat (20) step();
    checks++; if (fall0 != f0 || csn !== 1'b1) begin errors++; $display("FAIL dis_csn: got csn=%b falls_changed=%0d want 1/0", csn, fall0 != f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_busy: got %b want 0", busy); end
    checks++; if (missed !== 8'h00) begin errors++; $display("FAIL dis_missed: got %0d want 0", missed); end
    en = 1'b1;
    v0 = vcnt0;
    start_txn();
    goto(200);
    en = 1'b0;
    pulse_at(300);
    goto(660);
    checks++; if (vcnt0 - v0 != 1) begin errors++; $display("FAIL drop_valid_count: got %0d want 1", vcnt0 - v0); end
    checks++; if (vcyc0 - t0 != 646) begin errors++; $display("FAIL drop_valid_cycle: got %0d want 646", vcyc0 - t0); end
    checks++; if (missed !== 8'h00) begin errors++; $display("FAIL drop_missed: got %0d want 0", missed); end
    checks++; if (z !== 20'hFFFFF) begin errors++; $display("FAIL drop_z: got %h want fffff", z); end
    en = 1'b1;
    repeat (30) step();
    checks++; if (x !== 20'h12345) begin errors++; $display("FAIL hold_x: got %h want 12345", x); end
  endtask

  task automatic test_reset_mid();
    int v0;
    apply_reset();
    v0 = vcnt0;
    start_txn();
    pulse_at(100);
    goto(300);
    rst_n = 1'b0;
    #1;
    checks++; if ({csn, sclk, busy, valid} !== 4'b1000) begin errors++; $display("FAIL midrst_ctrl: got %b want 1000", {csn, sclk, busy, valid}); end
    checks++; if (missed !== 8'h00) begin errors++; $display("FAIL midrst_missed: got %0d want 0", missed); end
    goto(303);
    rst_n = 1'b1;
    stream = {8'h3C, 72'hABCDE1012345765432};
    goto(700);
    checks++; if (vcnt0 != v0) begin errors++; $display("FAIL midrst_no_valid: got %0d want 0", vcnt0 - v0); end
    v0 = vcnt0;
    start_txn();
    goto(660);
    checks++; if (vcnt0 - v0 != 1) begin errors++; $display("FAIL post_valid_count: got %0d want 1", vcnt0 - v0); end
    checks++; if (vcyc0 - t0 != 646) begin errors++; $display("FAIL post_valid_cycle: got %0d want 646", vcyc0 - t0); end
    checks++; if ({x, y, z} !== {20'hABCDE, 20'h01234, 20'h76543}) begin errors++; $display("FAIL post_xyz: got %h want abcde0123476543", {x, y, z}); end
    checks++; if (rises0_done != 80) begin errors++; $display("FAIL post_rises: got %0d want 80", rises0_done); end
  endtask

  task automatic test_fast();
    int v1;
    v1 = vcnt1;
    step();
    f_drdy = 1'b1;
    t0 = cyc;
    step();
    f_drdy = 1'b0;
    checks++; if ({f_csn, f_busy} !== 2'b01) begin errors++; $display("FAIL fast_start: got %b want 01", {f_csn, f_busy}); end
    goto(161);
    checks++; if (f_csn !== 1'b0) begin errors++; $display("FAIL fast_csn_161: got %b want 0", f_csn); end
    goto(162);
    checks++; if (f_csn !== 1'b1) begin errors++; $display("FAIL fast_csn_162: got %b want 1", f_csn); end
    goto(163);
    checks++; if (f_busy !== 1'b0) begin errors++; $display("FAIL fast_busy_163: got %b want 0", f_busy); end
    goto(170);
    checks++; if (vcnt1 - v1 != 1) begin errors++; $display("FAIL fast_valid_count: got %0d want 1", vcnt1 - v1); end
    checks++; if (vcyc1 - t0 != 163) begin errors++; $display("FAIL fast_valid_cycle: got %0d want 163", vcyc1 - t0); end
    checks++; if ({f_x, f_y, f_z} !== {20'hABCDE, 20'h01234, 20'h76543}) begin errors++; $display("FAIL fast_xyz: got %h want abcde0123476543", {f_x, f_y, f_z}); end
    checks++; if (rises1_done != 80) begin errors++; $display("FAIL fast_rises: got %0d want 80", rises1_done); end
    checks++; if (mcap1_done[79:72] !== 8'h11) begin errors++; $display("FAIL fast_mosi_cmd: got %h want 11", mcap1_done[79:72]); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_missed();
    test_saturate();
    test_enable();
    test_reset_mid();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adxl355_rd.md
# adxl355_rd

Reader at the far end of the ADXL355 DRDY path: on each 1-clock DRDY pulse it runs one SPI burst read of the accelerometer's X/Y/Z data registers (0x08..0x10). It unpacks the three 20-bit samples and presents them with a 1-clock valid strobe. It sits between the DRDY generator, whose `o_clk_drdy` drives `i_drdy`, and the sample consumer (FIFO or stream packer), and it owns the accelerometer's SPI pins.

## Interface
- `clk_hz`, 40000000: system clock rate in Hz.
- `spi_hz`, 5000000: target SCLK rate in Hz. Half-period H = clk_hz/(2*spi_hz) cycles, integer-truncated. H ≥ 1 is required and is checked at elaboration.
- `start_addr`, 8'h08: first register of the burst.
- `n_data`, 9: data bytes per burst.

Ports (clock and reset first):
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: reset, asynchronous assert, active-low.
- `i_enable` in 1: when 0, new DRDY pulses are ignored and are not counted as missed.
- `i_drdy` in 1: data-ready pulse, one `i_clk` wide, already synchronous to `i_clk`.
- `o_csn` out 1: SPI chip select, active-low.
- `o_sclk` out 1: SPI clock, mode 0, idles low.
- `o_mosi` out 1: SPI data to the device.
- `i_miso` in 1: SPI data from the device, synchronous to `i_clk`.
- `o_x`, `o_y`, `o_z` out 20 each: signed samples.
- `o_valid` out 1: 1-clock strobe; samples are new in this cycle.
- `o_busy` out 1: a transaction is in progress.
- `o_missed` out 8: saturating count of DRDY pulses dropped while busy.

## Operation
- States: IDLE → SETUP → SHIFT → DONE → GAP → IDLE.
- IDLE: `i_drdy` && `i_enable` → SETUP. Load the shift register with the command byte {start_addr[6:0],1'b1} (0x11), followed by zeros.
- SETUP: `o_csn`=0, `o_sclk`=0, `o_mosi` = command bit7. Lasts H cycles.
- SHIFT: 8*(1+n_data) = 80 bits, MSB first. Each bit is H cycles with `o_sclk`=1, then H cycles with `o_sclk`=0.
  - `i_miso` is sampled in the last cycle of each high phase.
  - `o_mosi` advances to the next bit when `o_sclk` falls.
  - The 8 bits sampled during the command byte are discarded.
- DONE: `o_csn`=1 for one cycle. The next cycle, `o_x`/`o_y`/`o_z` update and `o_valid`=1.
- Unpacking: byte i of data is d[i]. x = {d0,d1,d2[7:4]}, y = {d3,d4,d5[7:4]}, z = {d6,d7,d8[7:4]}. The low nibbles are dropped. The samples are two's complement and are passed through with no sign extension.
- GAP: `o_csn` stays high. Total CSN-high time before the next accept is H cycles.
- `i_drdy` in any non-IDLE state: the transaction continues unaffected, and `o_missed` increments unless it is at 255.
- `i_drdy` with `i_enable`=0: no transaction and no count.
- `i_enable` dropping mid-transaction: the current transaction completes normally.
- Reset mid-transaction: the state machine returns to IDLE at once, the outputs take their reset values, and the partial data is discarded.

## Timing
- Reset values: `o_csn`=1; `o_sclk`, `o_mosi`, `o_valid`, `o_busy` = 0; `o_x`, `o_y`, `o_z`, `o_missed` = 0.
- All outputs are registered.
- With `i_drdy` high in cycle 0 (in IDLE):
  - `o_csn`=0 and `o_busy`=1 from cycle 1.
  - k-th SCLK rise (k=0..79) at cycle 1+H+2Hk.
  - `o_csn`=1 at cycle 1+161H.
  - `o_valid` at cycle 2+161H.
  - `o_busy`=0, with a new accept possible, at cycle 1+162H.
- Defaults (H=4): CSN low for cycles 1..644, `o_valid` at cycle 646, IDLE again at cycle 649, about 16.2 µs. This fits inside the 1 kHz period.
- `o_x`/`o_y`/`o_z` hold their values between strobes.

## Structure
- Shared package `adxl355_pkg`:
  - register addresses (XDATA3 = 0x08, etc.)
  - read-command encode function
  - data byte count
  - sample width (20)
  - state enum
- One natural sub-module, `adxl355_sclk_tick`: the half-period counter. It emits a tick every H cycles while enabled and restarts on enable. The FSM and shift/unpack logic stay in `adxl355_rd`.

## Test plan
- SPI device model returns bytes 0x12,0x34,0x5F,0x80,0x00,0x0A,0xFF,0xFF,0xF3; one DRDY. Expected:
  - MOSI byte 0x11.
  - x=0x1234_5, y=0x8000_0, z=0xFFFF_F.
  - `o_valid` exactly at cycle 646 and for one cycle.
  - 80 SCLK rises.
- DRDY pulses at cycles 0, 100, 300 (all during busy). Expected: one transaction, `o_missed`=2. A DRDY at cycle 649 starts a second transaction.
- 300 DRDY pulses while busy. Expected: `o_missed` saturates at 255.
- `i_enable`=0 with DRDY. Expected: `o_csn` stays 1 and `o_missed` stays 0. With `i_enable` dropped at cycle 200 of a transaction, the transaction still completes and `o_valid` fires.
- `i_rst_n` asserted at cycle 300. Expected: outputs at reset values immediately, no `o_valid`; the next DRDY after release gives a clean full transaction.
- `spi_hz`=20 MHz (H=1). Expected: `o_valid` at cycle 163; sampling and data are still correct.
